// File: rtl/reset_sequencer.sv
// reset_sequencer: staged release of video, logic and display resets from the board button,
// frame-aligned, with a soft restart of the game logic domain.
module reset_sequencer #(
  parameter logic [19:0] HOLD_CYCLES   = 20'hfffff,
  parameter logic [19:0] STAGE_GAP     = 20'd16,
  parameter logic [19:0] SOFT_CYCLES   = 20'd256,
  parameter logic [19:0] FRAME_TIMEOUT = 20'hfffff
) (
  input  logic clk,
  input  logic rst_button,
  input  logic frame_tick,
  input  logic soft_req,
  output logic rst_video,
  output logic rst_logic,
  output logic rst_display,
  output logic ready,
  output logic soft_ack,
  output logic frame_timeout
);
  localparam logic [2:0] HOLD       = 3'd0;
  localparam logic [2:0] REL_VIDEO  = 3'd1;
  localparam logic [2:0] WAIT_FRAME = 3'd2;
  localparam logic [2:0] RUN        = 3'd3;
  localparam logic [2:0] SOFT       = 3'd4;

  logic [1:0]  sync_q;
  logic        seen_q;
  logic [2:0]  state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        soft_q, soft_d;
  logic        req_q;
  logic        timeout_d;
  logic        rst_video_q, rst_logic_q, rst_display_q, ready_q, soft_ack_q, frame_timeout_q;

  // seen_q marks the cycle after the synchronizer output goes high; HOLD counts from there
  always_comb begin
    state_d = (state_q == HOLD && seen_q && cnt_q == HOLD_CYCLES - 20'd1) ? REL_VIDEO :
              (state_q == REL_VIDEO && cnt_q == STAGE_GAP - 20'd1) ? WAIT_FRAME :
              (state_q == WAIT_FRAME && (frame_tick || cnt_q == FRAME_TIMEOUT - 20'd1)) ? RUN :
              (state_q == RUN && soft_req && !req_q) ? SOFT :
              (state_q == SOFT && cnt_q == SOFT_CYCLES - 20'd1) ? WAIT_FRAME :
              (state_q > SOFT) ? HOLD : state_q;
    cnt_d = (state_d != state_q || state_q == RUN || !seen_q) ? 20'd0 : cnt_q + 20'd1;
    soft_d = (state_q == SOFT && state_d == WAIT_FRAME) ? 1'b1 :
             (state_q == WAIT_FRAME && state_d == RUN) ? 1'b0 : soft_q;
    timeout_d = frame_timeout_q |
                (state_q == WAIT_FRAME && !frame_tick && cnt_q == FRAME_TIMEOUT - 20'd1);
  end

  always_ff @(posedge clk or negedge rst_button) begin
    if (!rst_button) begin
      sync_q          <= 2'b00;
      seen_q          <= 1'b0;
      state_q         <= HOLD;
      cnt_q           <= 20'd0;
      soft_q          <= 1'b0;
      req_q           <= 1'b0;
      rst_video_q     <= 1'b1;
      rst_logic_q     <= 1'b1;
      rst_display_q   <= 1'b1;
      ready_q         <= 1'b0;
      soft_ack_q      <= 1'b0;
      frame_timeout_q <= 1'b0;
    end else begin
      sync_q          <= {sync_q[0], 1'b1};
      seen_q          <= sync_q[1];
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      soft_q          <= soft_d;
      req_q           <= soft_req;
      rst_video_q     <= state_d == HOLD;
      rst_logic_q     <= state_d != RUN;
      rst_display_q   <= state_d == HOLD || state_d == REL_VIDEO || (state_d == WAIT_FRAME && !soft_d);
      ready_q         <= state_d == RUN;
      soft_ack_q      <= state_q == WAIT_FRAME && state_d == RUN && soft_q;
      frame_timeout_q <= timeout_d;
    end
  end

  assign rst_video     = rst_video_q;
  assign rst_logic     = rst_logic_q;
  assign rst_display   = rst_display_q;
  assign ready         = ready_q;
  assign soft_ack      = soft_ack_q;
  assign frame_timeout = frame_timeout_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed bench for the staged reset sequencer with small timing parameters.
module tb_reset_sequencer;
  logic clk, rst_button, frame_tick, soft_req;
  logic rst_video, rst_logic, rst_display, ready, soft_ack, frame_timeout;
  int errors = 0;
  int checks = 0;
  int hi, bad, acks, drops;

  reset_sequencer #(
    .HOLD_CYCLES(20'd16), .STAGE_GAP(20'd4), .SOFT_CYCLES(20'd8), .FRAME_TIMEOUT(20'd64)
  ) dut (
    .clk(clk), .rst_button(rst_button), .frame_tick(frame_tick), .soft_req(soft_req),
    .rst_video(rst_video), .rst_logic(rst_logic), .rst_display(rst_display),
    .ready(ready), .soft_ack(soft_ack), .frame_timeout(frame_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Releases the button just after an edge; tick_after=0 means no tick in the frame wait
  task automatic powerup(input bit early, input bit drop, input int tick_after);
    int fall, run, n_ack;
    fall = 0;
    run = 0;
    n_ack = 0;
    rst_button = 1'b1;
    repeat (3) step();
    for (int k = 1; k <= 20; k++) begin
      step();
      if (!rst_video && fall == 0) fall = k;
      frame_tick = early && (k == 4 || k == 17);
      if (drop) soft_req = (k == 16 || k >= 18);
    end
    chk("video_fall_edge", fall, 16);
    chk("logic_at_wait", rst_logic, 1);
    chk("display_at_wait", rst_display, 1);
    chk("ready_at_wait", ready, 0);
    for (int j = 1; j <= 70 && run == 0; j++) begin
      frame_tick = (tick_after != 0 && j == tick_after + 1);
      step();
      if (soft_ack) n_ack++;
      if (ready) run = j;
    end
    frame_tick = 1'b0;
    chk("run_edge", run, (tick_after != 0) ? tick_after + 1 : 64);
    chk("frame_timeout_flag", frame_timeout, (tick_after == 0) ? 1 : 0);
    chk("logic_released", rst_logic, 0);
    chk("display_released", rst_display, 0);
    chk("video_in_run", rst_video, 0);
    chk("no_ack_powerup", n_ack, 0);
  endtask

  initial begin
    rst_button = 1'b0;
    frame_tick = 1'b0;
    soft_req = 1'b0;
    repeat (3) step();
    chk("rst_video_reset", rst_video, 1);
    chk("rst_logic_reset", rst_logic, 1);
    chk("rst_display_reset", rst_display, 1);
    chk("ready_reset", ready, 0);
    chk("soft_ack_reset", soft_ack, 0);
    chk("frame_timeout_reset", frame_timeout, 0);

    powerup(1'b0, 1'b0, 10);

    soft_req = 1'b1;
    step();
    chk("soft_logic", rst_logic, 1);
    chk("soft_ready", ready, 0);
    chk("soft_video", rst_video, 0);
    chk("soft_display", rst_display, 0);
    hi = 1;
    bad = 0;
    for (int i = 1; i <= 13; i++) begin
      step();
      hi += int'(rst_logic);
      bad += int'(rst_video | rst_display | ready | soft_ack);
    end
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("soft_logic_high_cycles", hi, 14);
    chk("soft_side_domains", bad, 0);
    chk("soft_ack_pulse", soft_ack, 1);
    chk("soft_ready_back", ready, 1);
    chk("soft_logic_released", rst_logic, 0);
    acks = 0;
    drops = 0;
    for (int i = 1; i <= 25; i++) begin
      step();
      acks += int'(soft_ack);
      drops += int'(!ready);
    end
    soft_req = 1'b0;
    chk("soft_ack_once", acks, 0);
    chk("no_retrigger_held", drops, 0);
    chk("timeout_clear_after_soft", frame_timeout, 0);

    step();
    soft_req = 1'b1;
    step();
    chk("soft_again_logic", rst_logic, 1);
    repeat (2) step();
    #2 rst_button = 1'b0;
    #1;
    chk("midrst_video", rst_video, 1);
    chk("midrst_logic", rst_logic, 1);
    chk("midrst_display", rst_display, 1);
    chk("midrst_ready", ready, 0);
    chk("midrst_ack", soft_ack, 0);
    soft_req = 1'b0;
    repeat (2) step();
    chk("midrst_ack_held", soft_ack, 0);

    powerup(1'b0, 1'b1, 10);
    drops = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      drops += int'(!ready);
    end
    chk("dropped_req_no_soft", drops, 0);
    soft_req = 1'b0;
    step();
    soft_req = 1'b1;
    step();
    chk("fresh_edge_logic", rst_logic, 1);
    chk("fresh_edge_ready", ready, 0);

    rst_button = 1'b0;
    repeat (2) step();
    soft_req = 1'b0;
    powerup(1'b1, 1'b0, 0);
    repeat (10) step();
    chk("timeout_sticky", frame_timeout, 1);
    chk("timeout_ready", ready, 1);
    rst_button = 1'b0;
    #1;
    chk("timeout_cleared", frame_timeout, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Staged reset controller for the pong design. Takes the asynchronous active-low board reset button and releases three reset domains in a fixed order: video timing first, then game logic and score display together, aligned to a frame boundary. It also serves a soft-restart request from the game logic (restart after game over) without disturbing video timing. It replaces direct fan-out of a single power-on reset.

## Interface
- HOLD_CYCLES, 20'hfffff: cycles all domains stay in reset after the button is released.
- STAGE_GAP, 16: cycles between video release and the start of the frame wait.
- SOFT_CYCLES, 256: cycles rst_logic is held during a soft restart.
- FRAME_TIMEOUT, 20'hfffff: maximum cycles spent waiting for frame_tick.
- clk  input  1  system clock; all logic is on its rising edge.
- rst_button  input  1  asynchronous, active-low reset. Asserting it forces every output to its reset value immediately.
- frame_tick  input  1  one-cycle pulse from the video timing block at frame start. Synchronous to clk.
- soft_req  input  1  soft-restart request from game logic; rising-edge sensitive.
- rst_video  output  1  active-high reset for the VGA sync/timing block.
- rst_logic  output  1  active-high reset for game state (paddles, ball).
- rst_display  output  1  active-high reset for the score/display block.
- ready  output  1  high while in RUN.
- soft_ack  output  1  one-cycle pulse when a soft restart completes.
- frame_timeout  output  1  sticky flag: set when a frame wait expired; cleared only by rst_button.

## Operation
- Button synchronizer: two flops, asynchronously set to "in reset" by rst_button low and shifting in 1 after release. The FSM advances only when the synchronized release is seen. Assertion is asynchronous; deassertion is synchronous.
- FSM states:
  - HOLD: all resets are 1 and the counter increments. When counter = HOLD_CYCLES-1, go to REL_VIDEO and clear the counter.
  - REL_VIDEO: rst_video = 0; the other resets stay 1. When counter = STAGE_GAP-1, go to WAIT_FRAME and clear the counter.
  - WAIT_FRAME: rst_logic and rst_display stay 1 (for a soft restart, only rst_logic).
    - frame_tick = 1: go to RUN.
    - counter = FRAME_TIMEOUT-1 with no tick: set frame_timeout and go to RUN.
  - RUN: all resets are 0 and ready = 1. A soft_req rising edge (registered previous value 0, current value 1) goes to SOFT.
  - SOFT: rst_logic = 1 while rst_video and rst_display stay 0; ready = 0. When counter = SOFT_CYCLES-1, go to WAIT_FRAME with a soft flag set.
- Leaving WAIT_FRAME with the soft flag set pulses soft_ack for the first RUN cycle and clears the flag.
- soft_req edges outside RUN are dropped, not queued. The edge detector keeps tracking in all states, so a request held high across the restart does not re-trigger.
- Counter: a single 20-bit counter, cleared on every state transition. Parameters must be ≥1 and fit in 20 bits.

## Timing
- Reset values (rst_button low): rst_video = rst_logic = rst_display = 1; ready = soft_ack = frame_timeout = 0; state = HOLD; counter = 0; both synchronizer flops in the "reset" state.
- Let E1 be the first rising edge with rst_button high.
  - The synchronized release is seen at E2 and HOLD counting starts at E3.
  - rst_video falls HOLD_CYCLES edges after E3.
  - WAIT_FRAME is entered STAGE_GAP edges later.
- A frame_tick sampled high in WAIT_FRAME at edge N gives:
  - rst_logic and rst_display falling together after edge N;
  - ready rising after edge N;
  - soft_ack high for one cycle after edge N, if soft.
- A frame_tick arriving while in HOLD or REL_VIDEO is ignored.
- frame_tick and the timeout hitting on the same edge count as a tick: frame_timeout is not set.
- Soft restart: a soft_req edge sampled at edge M puts rst_logic and ready into their SOFT values after M. The frame wait begins SOFT_CYCLES edges later.
- rst_button asserted mid-sequence (any state, including SOFT) returns to reset values asynchronously. A pending soft flag is discarded and no soft_ack is issued.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Bench parameters for every scenario: HOLD_CYCLES = 16, STAGE_GAP = 4, SOFT_CYCLES = 8, FRAME_TIMEOUT = 64.
- Power-up: release rst_button at E1, pulse frame_tick 10 cycles after WAIT_FRAME entry.
  - rst_video falls exactly 16 edges after E3.
  - rst_logic, rst_display and ready switch exactly 11 edges after WAIT_FRAME entry.
  - frame_timeout stays 0.
- Frame timeout: give no frame_tick.
  - RUN is entered 64 edges after WAIT_FRAME entry.
  - frame_timeout = 1 and stays set until rst_button is pulsed.
- Soft restart: in RUN, raise soft_req and hold it for 40 cycles; pulse frame_tick 5 cycles after the frame wait starts.
  - rst_logic is high for 8 + 6 cycles while rst_video and rst_display stay 0.
  - soft_ack pulses once, and there is no second restart while soft_req remains high.
- Dropped request: pulse soft_req during REL_VIDEO, then hold it high.
  - No SOFT entry after RUN is reached.
  - A fresh 0→1 edge in RUN triggers SOFT.
- Mid-operation reset: assert rst_button between clock edges during SOFT.
  - All resets go to 1 before the next edge, ready = 0 and soft_ack never pulses.
  - After release, the full power-up sequence repeats with identical counts.
- Early tick: pulse frame_tick during HOLD and REL_VIDEO only.
  - The FSM waits in WAIT_FRAME, and times out at 64 cycles if there are no further ticks.
